// File: rtl/lvds_deframer_if.sv
// Nibble-stream input and decoded-packet output bundle for the LVDS deframer.
// The receive side has no backpressure: nibbles are accepted whenever nv is high.
interface lvds_deframer_if;
  logic [3:0]  d;
  logic        nv;
  logic        l;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        wv;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (output d, nv, l, input addr, data, wv, err, err_cnt);
  modport slave  (input d, nv, l, output addr, data, wv, err, err_cnt);
endinterface

// File: rtl/lvds_deframer.sv
// Deframes 12-nibble packets (addr, data, CRC-8) and publishes good ones; wv/err one cycle after the deciding nibble.
// No backpressure: every nv nibble is consumed, nv=0 freezes all state.
module lvds_deframer #(
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic            c,
  input  logic            rst_n,
  lvds_deframer_if.slave  rx
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR     = 3'd1;
  localparam logic [2:0] BODY    = 3'd2;
  localparam logic [2:0] CRC     = 3'd3;
  localparam logic [2:0] DISCARD = 3'd4;

  function automatic logic [7:0] crc_nib(input logic [7:0] crc_in, input logic [3:0] nib);
    logic [7:0] r;
    logic       fb;
    r = crc_in;
    for (int i = 3; i >= 0; i--) begin
      fb = r[7] ^ nib[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Release is synchronised; assertion still reaches all state immediately.
  logic [1:0] rsync;
  logic       srst_n;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  end

  assign srst_n = rsync[1];

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [7:0]  crc_q;
  logic [3:0]  crc_hi;
  logic [39:0] sh;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic        wv_q;
  logic        err_q;
  logic [7:0]  err_cnt_q;
  logic        fire_err;
  logic        fire_wv;
  logic        crc_match;

  always_comb begin
    fire_err  = 1'b0;
    fire_wv   = 1'b0;
    crc_match = ({crc_hi, rx.d} == crc_q);
    if (rx.nv) begin
      case (state)
        IDLE, HDR, BODY: fire_err = rx.l;
        CRC: begin
          if (cnt == 4'd10) begin
            fire_err = rx.l;
          end else begin
            fire_err = !rx.l || !crc_match;
            fire_wv  = rx.l && crc_match;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge c or negedge srst_n) begin
    if (!srst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      crc_q     <= CRC_INIT;
      crc_hi    <= 4'd0;
      sh        <= 40'd0;
      addr_q    <= 8'h00;
      data_q    <= 32'h0;
      wv_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      wv_q  <= fire_wv;
      err_q <= fire_err;
      if (fire_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (fire_wv) begin
        addr_q <= sh[39:32];
        data_q <= sh[31:0];
      end
      if (rx.nv) begin
        case (state)
          IDLE: begin
            if (!rx.l) begin
              sh    <= {36'd0, rx.d};
              crc_q <= crc_nib(CRC_INIT, rx.d);
              cnt   <= 4'd1;
              state <= HDR;
            end
          end
          HDR, BODY: begin
            if (rx.l) begin
              state <= IDLE;
              cnt   <= 4'd0;
              crc_q <= CRC_INIT;
            end else begin
              sh    <= {sh[35:0], rx.d};
              crc_q <= crc_nib(crc_q, rx.d);
              cnt   <= cnt + 4'd1;
              if (state == HDR)      state <= BODY;
              else if (cnt == 4'd9)  state <= CRC;
            end
          end
          CRC: begin
            if (cnt == 4'd10 && !rx.l) begin
              crc_hi <= rx.d;
              cnt    <= 4'd11;
            end else begin
              // Missing last flag on nibble 11 means the frame boundary is lost.
              state <= (cnt == 4'd11 && !rx.l) ? DISCARD : IDLE;
              cnt   <= 4'd0;
              crc_q <= CRC_INIT;
            end
          end
          DISCARD: if (rx.l) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rx.addr    = addr_q;
  assign rx.data    = data_q;
  assign rx.wv      = wv_q;
  assign rx.err     = err_q;
  assign rx.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lvds_deframer.sv
// Scoreboard bench for lvds_deframer: expected wv/err events queued at stimulus time, matched as pulses appear.
module tb_lvds_deframer;

  logic c = 1'b0;
  logic rst_n = 1'b0;

  lvds_deframer_if bus ();

  lvds_deframer #(.CRC_INIT(8'h00)) dut (
    .c     (c),
    .rst_n (rst_n),
    .rx    (bus)
  );

  always #5 c = ~c;

  typedef struct {
    logic        is_wv;
    logic [7:0]  a;
    logic [31:0] dt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_errcnt = 8'h00;
  logic        mon_en = 1'b0;
  logic [7:0]  last_a = 8'h00;
  logic [31:0] last_d = 32'h0;
  logic [3:0]  raw [12];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC computed bytewise over addr then data bytes.
  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [31:0] dt);
    logic [39:0] msg;
    logic [7:0]  r;
    msg = {a, dt};
    r   = 8'h00;
    for (int b = 4; b >= 0; b--) begin
      r = r ^ msg[b*8 +: 8];
      for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  always @(negedge c) begin
    if (mon_en && (bus.wv || bus.err)) begin
      check("wv_err_excl", 40'(bus.wv & bus.err), 40'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 40'({bus.wv, bus.err}), 40'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_wv", 40'(bus.wv), 40'(mon_e.is_wv));
        if (mon_e.is_wv) begin
          check("addr", 40'(bus.addr), 40'(mon_e.a));
          check("data", 40'(bus.data), 40'(mon_e.dt));
        end else if (exp_errcnt != 8'hFF) begin
          exp_errcnt = exp_errcnt + 8'd1;
        end
        check("err_cnt", 40'(bus.err_cnt), 40'(exp_errcnt));
      end
    end
  end

  task automatic nib(input logic [3:0] v, input logic last, input int gap);
    bus.d  = v;
    bus.nv = 1'b1;
    bus.l  = last;
    @(posedge c); #1;
    bus.nv = 1'b0;
    bus.l  = 1'b0;
    repeat (gap) begin @(posedge c); #1; end
  endtask

  task automatic push_exp(input logic good, input logic [7:0] a, input logic [31:0] dt);
    exp_t e;
    e.is_wv = good;
    e.a     = a;
    e.dt    = dt;
    sb.push_back(e);
    if (good) begin
      last_a = a;
      last_d = dt;
    end
  endtask

  task automatic pkt(input logic [7:0] a, input logic [31:0] dt, input logic bad, input int gap);
    logic [47:0] w;
    logic [7:0]  cr;
    cr = crc8(a, dt);
    if (bad) cr = cr ^ 8'(1 << $urandom_range(0, 7));
    w = {a, dt, cr};
    push_exp(!bad, a, dt);
    for (int i = 11; i >= 0; i--) nib(w[i*4 +: 4], i == 0, gap);
  endtask

  task automatic send_raw(input int gap);
    for (int i = 0; i < 12; i++) nib(raw[i], i == 11, gap);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin @(posedge c); #1; end
    @(posedge c); #1;
    check("scoreboard_drain", 40'(sb.size()), 40'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.d  = 4'h0;
    bus.nv = 1'b0;
    bus.l  = 1'b0;
    repeat (3) @(posedge c);
    #1;
    check("rst_addr", 40'(bus.addr), 40'd0);
    check("rst_data", 40'(bus.data), 40'd0);
    check("rst_wv", 40'(bus.wv), 40'd0);
    check("rst_err", 40'(bus.err), 40'd0);
    check("rst_err_cnt", 40'(bus.err_cnt), 40'd0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge c); #1; end
    mon_en = 1'b1;

    // All-zero packet, nv every other cycle.
    pkt(8'h00, 32'h0, 1'b0, 1);
    drain();
    check("zero_pkt_err_cnt", 40'(bus.err_cnt), 40'd0);

    // Literal nibble streams with known CRC 0x62.
    raw = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h2};
    push_exp(1'b1, 8'h01, 32'h0);
    send_raw(0);
    drain();
    raw[11] = 4'h3;
    push_exp(1'b0, 8'h00, 32'h0);
    send_raw(0);
    drain();
    check("bad_crc_addr_hold", 40'(bus.addr), 40'h01);
    check("bad_crc_data_hold", 40'(bus.data), 40'h0);
    check("bad_crc_err_cnt", 40'(bus.err_cnt), 40'd1);

    // Early last flag, then a good packet.
    push_exp(1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 6; i++) nib(4'h0, i == 5, 0);
    pkt(8'h00, 32'h0, 1'b0, 0);
    drain();

    // Overlong packet: one error at nibble 11, silent discard to the flag.
    push_exp(1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 14; i++) nib(4'h0, i == 13, 0);
    pkt(8'hA5, 32'hDEADBEEF, 1'b0, 0);
    drain();

    // Last flag on nibble 0.
    push_exp(1'b0, 8'h00, 32'h0);
    nib(4'h3, 1'b1, 2);
    drain();

    for (int n = 0; n < 16; n++) begin
      pkt(8'($urandom), 32'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end
    drain();
    check("rand_addr_hold", 40'(bus.addr), 40'(last_a));
    check("rand_data_hold", 40'(bus.data), 40'(last_d));

    // Reset mid-packet.
    for (int i = 0; i < 7; i++) nib(4'($urandom), 1'b0, 0);
    rst_n = 1'b0;
    #2;
    exp_errcnt = 8'h00;
    last_a = 8'h00;
    last_d = 32'h0;
    check("midrst_addr", 40'(bus.addr), 40'd0);
    check("midrst_data", 40'(bus.data), 40'd0);
    check("midrst_wv", 40'(bus.wv), 40'd0);
    check("midrst_err", 40'(bus.err), 40'd0);
    check("midrst_err_cnt", 40'(bus.err_cnt), 40'd0);
    @(posedge c); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge c); #1; end
    pkt(8'h3C, 32'h12345678, 1'b0, 1);
    drain();

    // Saturate the error counter with back-to-back framing errors.
    for (int i = 0; i < 300; i++) begin
      push_exp(1'b0, 8'h00, 32'h0);
      nib(4'h0, 1'b1, 0);
    end
    drain();
    check("err_cnt_sat", 40'(bus.err_cnt), 40'hFF);
    pkt(8'h5A, 32'hCAFEF00D, 1'b0, 0);
    drain();
    check("sat_hold_after_good", 40'(bus.err_cnt), 40'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_deframer.md
LVDS_DEFRAMER -- requirements
Module: lvds_deframer

Interface
REQ-001 c  input  1  receive clock, 400 MHz; all logic on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-003 d  input  4  received nibble from data recovery unit; first nibble of packet is most significant.
REQ-004 nv  input  1  nibble strobe; d and l sampled only when nv=1; back-to-back nv permitted.
REQ-005 l  input  1  last flag; qualified by nv; marks final nibble of a packet.
REQ-006 addr  output  8  address of last good packet.
REQ-007 data  output  32  data word of last good packet.
REQ-008 wv  output  1  one-cycle pulse: addr/data updated with a good packet.
REQ-009 err  output  1  one-cycle pulse: packet rejected (CRC or framing).
REQ-010 err_cnt  output  8  saturating count of rejected packets.
REQ-011 Parameter CRC_INIT, default 8'h00, CRC-8 initial value.

Function
REQ-012 Packet SHALL be exactly 12 nibbles: 2 address (MSB first), 8 data (MSB first), 2 CRC (MSB first); l SHALL accompany nibble 11 (0-based).
REQ-013 CRC SHALL be CRC-8, polynomial x^8+x^2+x+1 (0x07), no reflection, no final XOR, over the 10 address/data nibbles, one nibble per nv, MSB first; result SHALL equal bytewise CRC of addr, data[31:24] ... data[7:0].
REQ-014 State machine SHALL have states IDLE, HDR, BODY, CRC, DISCARD.
REQ-015 IDLE: on nv, nibble latched as nibble 0, CRC seeded from CRC_INIT, nibble counter 1, go HDR; if l also set -> framing error, stay IDLE.
REQ-016 HDR (nibble 1) -> BODY; BODY (nibbles 2-9) -> CRC after nibble 9; CRC state takes nibbles 10-11.
REQ-017 l=1 on any nibble 1-10 SHALL be a framing error: err pulse, return IDLE, addr/data unchanged.
REQ-018 Nibble 11 with l=0 SHALL be a framing error: err pulse, go DISCARD.
REQ-019 DISCARD SHALL ignore nibbles until a nibble with l=1, then go IDLE with no further err pulse.
REQ-020 Nibble 11 with l=1: if received CRC equals computed CRC, addr/data SHALL update and wv pulse; else err pulse, addr/data unchanged; either way go IDLE.
REQ-021 wv/err latency: asserted in cycle after the edge sampling the deciding nibble; exactly one cycle; never both high.
REQ-022 err_cnt SHALL increment by 1 per err pulse and hold at 8'hFF.
REQ-023 nv=0 SHALL freeze all state, counter and CRC; no timeout.
REQ-024 Nibble counter 4 bits, never wraps: resets to 0 on every return to IDLE.
REQ-025 Assembly shift register SHALL be separate from addr/data outputs; partial packets never visible on outputs.

Reset
REQ-026 While rst_n=0: state IDLE, counter 0, CRC=CRC_INIT, addr=8'h00, data=32'h0, wv=0, err=0, err_cnt=0.
REQ-027 rst_n low mid-packet SHALL discard the partial packet with no wv/err pulse; after release the next nv nibble is nibble 0.
REQ-028 Release of rst_n SHALL be synchronised; first nibble accepted no earlier than 2nd edge after release.

Verification
REQ-029 12 nibbles all 0x0, nv every other cycle, l on 12th -> wv one cycle, addr=0x00, data=0x00000000, err_cnt=0.
REQ-030 Nibbles 0,1,0,0,0,0,0,0,0,0,6,2 back-to-back, l on last -> wv, addr=0x01, data=0x00000000.
REQ-031 Same as REQ-030 with CRC nibbles 6,3 -> err pulse, no wv, addr/data hold previous, err_cnt=1.
REQ-032 l on nibble 5 then valid zero packet -> err pulse at nibble 5, then wv for second packet, err_cnt=1.
REQ-033 14 nibbles, l only on 14th, then valid packet -> one err at nibble 11, none at 14, wv for next packet.
REQ-034 rst_n low after nibble 6 -> all outputs to reset values; following valid packet yields wv; 300 framing errors -> err_cnt=0xFF.
